// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, LSB-first payload, optional even/odd parity, stop bit.
// All outputs are registered; frame settings are captured at accept and held for the whole frame.
module uart_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_IN = 5
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic [PRESCALE_IN-1:0] prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic                   TX_OUT,
    output logic                   BUSY,
    output logic                   TX_DONE,
    output logic [2:0]             dbg_state_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_IN-1:0] P_MIN    = PRESCALE_IN'(4);
    localparam logic [PRESCALE_IN-1:0] ONE_P    = PRESCALE_IN'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                   state_q;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic [PRESCALE_IN-1:0]   presc_q;
    logic [PRESCALE_IN-1:0]   cnt_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     tx_q;
    logic                     busy_q;
    logic                     done_q;

    logic [PRESCALE_IN-1:0]   presc_d;
    logic                     par_bit_d;
    logic                     bit_end;
    logic                     stop_pre_end;

    // Prescale values below 4 are clamped so every bit spans at least four clocks.
    always_comb begin
        presc_d      = (prescale < P_MIN) ? P_MIN : prescale;
        par_bit_d    = (^P_DATA) ^ PAR_TYP;
        bit_end      = (cnt_q == presc_q);
        stop_pre_end = (cnt_q == (presc_q - ONE_P));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    if (DATA_VALID && !busy_q) begin
                        shift_q   <= P_DATA;
                        presc_q   <= presc_d;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= par_bit_d;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= ONE_P;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= ONE_P;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + ONE_P;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= ONE_P;
                        if (idx_q == IDX_LAST) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE_P;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= ONE_P;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + ONE_P;
                    end
                end
                STOP: begin
                    // Raised one clock early so the registered pulse lines up with the final stop cycle.
                    if (stop_pre_end) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + ONE_P;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign TX_OUT      = tx_q;
    assign BUSY        = busy_q;
    assign TX_DONE     = done_q;
    assign dbg_state_o = state_q;

endmodule
